// File: rtl/sw_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sw_conditioner                                                |
// | Purpose  : 2-flop synchronizer + per-switch debounce for 8 board switches |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sw_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic [7:0] SW_IN,
  output logic [7:0] SW_OUT,
  output logic       SW_CHANGED
);

  localparam int unsigned      c_nsw      = 8;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [c_nsw-1:0] r_sync1;
  logic [c_nsw-1:0] r_sync2;
  logic [c_nsw-1:0] r_sw_out;
  logic             r_changed;
  logic [c_nsw-1:0] w_differs;
  logic [c_nsw-1:0] w_accept;

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SW_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differs = r_sync2 ^ r_sw_out;

  genvar gi;
  generate
    for (gi = 0; gi < c_nsw; gi++) begin : g_sw
      logic [CNT_W-1:0] r_cnt;

      // Acceptance happens on the DEBOUNCE_CYCLES-th consecutive differing edge.
      assign w_accept[gi] = w_differs[gi] && (r_cnt == c_cnt_last);

      always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
          r_cnt <= '0;
        end else if (!w_differs[gi] || w_accept[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_sw_out  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sw_out  <= r_sw_out ^ w_accept;
      r_changed <= |w_accept;
    end
  end

  assign SW_OUT     = r_sw_out;
  assign SW_CHANGED = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_sw_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sw_conditioner                                             |
// | Purpose  : scoreboard bench for sw_conditioner, window-based ref model    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sw_conditioner;

  localparam int D = 16;

  logic       CLK = 1'b0;
  logic       ARST_L;
  logic [7:0] SW_IN;
  logic [7:0] SW_OUT;
  logic       SW_CHANGED;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc    = 0;

  sw_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .CLK       (CLK),
    .ARST_L    (ARST_L),
    .SW_IN     (SW_IN),
    .SW_OUT    (SW_OUT),
    .SW_CHANGED(SW_CHANGED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bit is accepted when the synchronized level has disagreed
  // with the accepted level on each of the last D edges.
  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] samp[$];
  logic [7:0] s2h[$];
  logic [7:0] m_out = 8'h00;

  always @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      samp.delete();
      s2h.delete();
      samp.push_back(8'h00);
      samp.push_back(8'h00);
      m_out = 8'h00;
      sb.delete();
      if (CLK) cyc++;
    end else begin
      logic [7:0] acc;
      logic [7:0] ent;
      logic       all;
      cyc++;
      s2h.push_back(samp[samp.size()-2]);
      acc = 8'h00;
      if (s2h.size() >= D) begin
        for (int b = 0; b < 8; b++) begin
          all = 1'b1;
          for (int j = 0; j < D; j++) begin
            ent = s2h[s2h.size()-1-j];
            if (ent[b] == m_out[b]) all = 1'b0;
          end
          acc[b] = all;
        end
      end
      if (acc != 8'h00) begin
        m_out = m_out ^ acc;
        sb.push_back('{val: m_out, cyc: cyc});
      end
      samp.push_back(SW_IN);
      while (samp.size() > 4) void'(samp.pop_front());
      while (s2h.size() > D + 2) void'(s2h.pop_front());
    end
  end

  // Monitor: pops an expectation whenever the DUT strobes SW_CHANGED.
  always @(negedge CLK) begin
    exp_t e;
    if (SW_CHANGED) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {24'h0, SW_OUT}, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("pulse_value", {24'h0, SW_OUT}, {24'h0, e.val});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_pulse", 32'(SW_CHANGED), 32'd1);
    end
    chk("sw_out_track", {24'h0, SW_OUT}, {24'h0, m_out});
    if (!ARST_L) chk("changed_in_reset", 32'(SW_CHANGED), 32'd0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Returns edges until SW_CHANGED is seen (-1 on timeout); ends 1 ns after that edge.
  task automatic wait_changed(input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(posedge CLK);
      edges++;
      #1;
      if (SW_CHANGED) return;
    end
    edges = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int p0;
    logic [7:0] msk;

    // Reset with 8'h02 held; release at 10 ns.
    ARST_L = 1'b0;
    SW_IN  = 8'h02;
    #7;
    chk("reset_sw_out", {24'h0, SW_OUT}, 32'h0);
    chk("reset_changed", 32'(SW_CHANGED), 32'd0);
    #3;
    ARST_L = 1'b1;
    wait_changed(40, e);
    chk("release_latency", e, 18);
    chk("release_value", {24'h0, SW_OUT}, 32'h02);
    #1;

    // Return to zero, then a 10-cycle glitch on bit 0 must be filtered.
    SW_IN = 8'h00;
    wait_changed(40, e);
    chk("clear_value", {24'h0, SW_OUT}, 32'h00);
    step(3);
    p0 = pulses;
    SW_IN = 8'h01;
    step(10);
    SW_IN = 8'h00;
    step(30);
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_value", {24'h0, SW_OUT}, 32'h00);

    // Bit 3 bouncing every 3 cycles, then held high.
    p0 = pulses;
    for (int t = 0; t < 10; t++) begin
      SW_IN[3] = ~SW_IN[3];
      step(3);
    end
    SW_IN[3] = 1'b1;
    wait_changed(40, e);
    chk("bounce_latency", e, 18);
    chk("bounce_value", {24'h0, SW_OUT}, 32'h08);
    #1;
    step(20);
    chk("bounce_pulses", pulses - p0, 1);

    // Two bits on one edge.
    SW_IN = 8'h00;
    wait_changed(40, e);
    #1;
    step(3);
    p0 = pulses;
    SW_IN = 8'h81;
    wait_changed(40, e);
    chk("pair_latency", e, 18);
    chk("pair_value", {24'h0, SW_OUT}, 32'h81);
    #1;
    step(20);
    chk("pair_pulses", pulses - p0, 1);

    // Staggered bits five cycles apart.
    SW_IN = 8'h00;
    wait_changed(40, e);
    #1;
    step(3);
    p0 = pulses;
    SW_IN = 8'h01;
    step(5);
    SW_IN = 8'h81;
    wait_changed(40, e);
    chk("stagger_first_value", {24'h0, SW_OUT}, 32'h01);
    wait_changed(40, e);
    chk("stagger_gap", e, 5);
    chk("stagger_second_value", {24'h0, SW_OUT}, 32'h81);
    #1;
    step(20);
    chk("stagger_pulses", pulses - p0, 2);

    // Reset in the middle of a pending change (count 10).
    SW_IN = 8'h91;
    step(12);
    ARST_L = 1'b0;
    #1;
    chk("midreset_sw_out", {24'h0, SW_OUT}, 32'h0);
    chk("midreset_changed", 32'(SW_CHANGED), 32'd0);
    #5;
    ARST_L = 1'b1;
    wait_changed(40, e);
    chk("midreset_latency", e, 18);
    chk("midreset_value", {24'h0, SW_OUT}, 32'h91);
    #1;

    // Randomized hold lengths straddling the debounce threshold.
    for (int n = 0; n < 150; n++) begin
      msk = 8'($urandom);
      if ($urandom_range(0, 3) == 0) msk = 8'h01 << $urandom_range(0, 7);
      SW_IN = SW_IN ^ msk;
      if (n == 75) begin
        ARST_L = 1'b0;
        #2;
        ARST_L = 1'b1;
      end
      step($urandom_range(1, 40));
    end

    step(D + 6);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
